// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_t         - frame-level FSM states
//   PAR_NONE/ODD/EVEN    - encodings for the PARITY parameter
//   CLKS_PER_BIT_DEFAULT - default baud divisor (100 MHz / 115200)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter.
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   clear   - hold the counter at 0 (used while the line is idle)
//   bit_end - high on the last cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bit_end = !clear && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter.
//   clk      - system clock
//   reset    - asynchronous active-low reset (aborts any frame in flight)
//   tx_start - request to send din, honoured only while idle
//   din      - byte to send, captured on acceptance (bits >= DATA_BITS ignored)
//   tx       - registered serial line, idle high
//   tx_busy  - high while a frame is on the line
//   tx_done  - one-cycle pulse in the first idle cycle after a frame
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg == ST_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      shreg_reg   <= '0;
      bit_idx_reg <= '0;
      par_reg     <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_idx_reg <= bit_idx_next;
      par_reg     <= par_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_idx_next = bit_idx_reg;
    par_next     = par_reg;

    case (state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          state_next   = ST_START;
          shreg_next   = din[DATA_BITS-1:0];
          bit_idx_next = '0;
          // Parity is fixed at capture so it is independent of the shifting.
          par_next     = (^din[DATA_BITS-1:0]) ^ (PARITY == PAR_ODD);
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_next = {1'b0, shreg_reg[DATA_BITS-1:1]};
          if (bit_idx_reg == LAST_DATA) begin
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next   = ST_STOP;
          bit_idx_next = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_reg == LAST_STOP) begin
            state_next = ST_IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line outputs are decoded from the next state so they change on the same
  // edge as the state itself (tx falls on the accepting edge).
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shreg_next[0];
      ST_PARITY: tx_next = par_reg;
      default:   tx_next = 1'b1;
    endcase
    busy_next = (state_next != ST_IDLE);
    done_next = (state_reg == ST_STOP) && (state_next == ST_IDLE);
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_v [4];
  logic [7:0] din_v   [4];
  logic       tx_v    [4];
  logic       busy_v  [4];
  logic       done_v  [4];

  // Per-instance configuration, mirrored from the instance parameters below.
  int cpb_t  [4] = '{4, 4, 4, 3};
  int par_t  [4] = '{0, 2, 1, 0};
  int stop_t [4] = '{1, 1, 1, 2};

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .reset(reset), .tx_start(start_v[0]), .din(din_v[0]),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_d1 (
    .clk(clk), .reset(reset), .tx_start(start_v[1]), .din(din_v[1]),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d2 (
    .clk(clk), .reset(reset), .tx_start(start_v[2]), .din(din_v[2]),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_d3 (
    .clk(clk), .reset(reset), .tx_start(start_v[3]), .din(din_v[3]),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in an idle (or tx_done) cycle. Sends byte b on
  // instance sel and checks the frame cycle by cycle until the tx_done cycle,
  // returning at the negedge of that cycle. With inject set, a second
  // tx_start (din=0x3C) is driven mid-frame and must be ignored.
  task automatic frame(input int sel, input logic [7:0] b, input bit inject);
    int cpb, nbits, len;
    bit busy_ok, done_early, levels_ok;
    logic [15:0] bits;
    logic [7:0] got, exp;
    logic exp_par;
    cpb   = cpb_t[sel];
    nbits = 1 + 8 + ((par_t[sel] != 0) ? 1 : 0) + stop_t[sel];
    len   = nbits * cpb;
    start_v[sel] = 1'b1;
    din_v[sel]   = b;
    sb.push_back(b);
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    din_v[sel]   = 8'($urandom);
    busy_ok = 1'b1; done_early = 1'b0; levels_ok = 1'b1; bits = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (inject && k == 12) begin start_v[sel] = 1'b1; din_v[sel] = 8'h3C; end
      if (inject && k == 13) start_v[sel] = 1'b0;
      if (busy_v[sel] !== 1'b1) busy_ok = 1'b0;
      if (done_v[sel] !== 1'b0) done_early = 1'b1;
      if (k % cpb == cpb / 2) bits[k / cpb] = tx_v[sel];
      if (k % cpb != 0 && tx_v[sel] !== bits[k / cpb] && k % cpb > cpb / 2) levels_ok = 1'b0;
    end
    @(negedge clk);
    exp = sb.pop_front();
    got = bits[8:1];
    $display("frame sel=%0d sent=%02h decoded=%02h", sel, b, got);
    check_val($sformatf("start_bit_%0d", sel), 32'(bits[0]), 32'd0);
    check_val($sformatf("data_%0d", sel), 32'(got), 32'(exp));
    if (par_t[sel] != 0) begin
      exp_par = (par_t[sel] == 2) ? ^exp : ~^exp;
      check_val($sformatf("parity_%0d", sel), 32'(bits[9]), 32'(exp_par));
    end
    for (int s = 0; s < stop_t[sel]; s++)
      check_val($sformatf("stop_bit_%0d", sel), 32'(bits[nbits - 1 - s]), 32'd1);
    check_val($sformatf("bit_stable_%0d", sel), 32'(levels_ok), 32'd1);
    check_val($sformatf("busy_in_frame_%0d", sel), 32'(busy_ok), 32'd1);
    check_val($sformatf("no_early_done_%0d", sel), 32'(done_early), 32'd0);
    check_val($sformatf("done_at_end_%0d", sel), 32'(done_v[sel]), 32'd1);
    check_val($sformatf("busy_low_done_%0d", sel), 32'(busy_v[sel]), 32'd0);
    check_val($sformatf("tx_idle_done_%0d", sel), 32'(tx_v[sel]), 32'd1);
  endtask

  initial begin
    bit done_seen;
    for (int i = 0; i < 4; i++) begin start_v[i] = 1'b0; din_v[i] = 8'h00; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_val("reset_tx", 32'(tx_v[i]), 32'd1);
      check_val("reset_busy", 32'(busy_v[i]), 32'd0);
      check_val("reset_done", 32'(done_v[i]), 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    frame(0, 8'hA5, 1'b0);
    @(negedge clk);
    frame(1, 8'h07, 1'b0);
    @(negedge clk);
    frame(2, 8'h07, 1'b0);
    @(negedge clk);
    frame(3, 8'h80, 1'b0);
    @(negedge clk);

    // Mid-frame request must be dropped, not queued.
    frame(0, 8'h11, 1'b1);
    repeat (2) @(negedge clk);
    check_val("no_queued_frame", 32'(busy_v[0]), 32'd0);
    check_val("no_queued_tx", 32'(tx_v[0]), 32'd1);

    // Back-to-back: each new request lands on the tx_done cycle.
    for (int i = 0; i < 16; i++) frame(0, 8'(i), 1'b0);
    @(negedge clk);

    // Asynchronous reset during data bit 3 of 0xFF.
    start_v[0] = 1'b1; din_v[0] = 8'hFF;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    check_val("pre_reset_busy", 32'(busy_v[0]), 32'd1);
    reset = 1'b0;
    #1;
    check_val("async_reset_tx", 32'(tx_v[0]), 32'd1);
    check_val("async_reset_busy", 32'(busy_v[0]), 32'd0);
    done_seen = 1'b0;
    repeat (3) @(negedge clk) if (done_v[0]) done_seen = 1'b1;
    reset = 1'b1;
    repeat (50) @(negedge clk) if (done_v[0]) done_seen = 1'b1;
    check_val("no_done_after_abort", 32'(done_seen), 32'd0);
    frame(0, 8'h55, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
